// File: rtl/log_capture.sv
// Sample-capture RAM: once armed by a rising in_run, records one in_data word per valid
// cycle until full. RAM contents, a status word or a live sample are read back with 2-cycle latency.
module log_capture #(
  parameter int NB_GPIOS            = 32,
  parameter int NB_ADDR             = 10,
  parameter int NB_LOG_READ_DEVICES = 2
) (
  input  logic                           clock,
  input  logic                           in_reset,
  input  logic [NB_GPIOS-1:0]            in_data,
  input  logic                           in_valid,
  input  logic                           in_run,
  input  logic [NB_LOG_READ_DEVICES-1:0] in_read_devices,
  input  logic [NB_ADDR-1:0]             in_read_addr,
  output logic [NB_GPIOS-1:0]            out_log_capture_data,
  output logic                           out_full
);

  localparam int DEPTH = 2 ** NB_ADDR;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DONE    = 2'b10
  } state_t;

  state_t                           state;
  logic                             run_d;
  logic [NB_ADDR-1:0]               wr_ptr;
  logic [NB_ADDR:0]                 count;
  logic [NB_GPIOS-1:0]              mem [DEPTH];

  logic                             rise;
  logic                             fall;
  logic                             write_en;
  logic                             last_write;
  logic [NB_GPIOS-1:0]              status;

  logic [NB_LOG_READ_DEVICES-1:0]   sel_q;
  logic [NB_GPIOS-1:0]              ram_q;
  logic [NB_GPIOS-1:0]              status_q;
  logic [NB_GPIOS-1:0]              live_q;
  logic [NB_GPIOS-1:0]              out_next;

  assign rise       = in_run & ~run_d;
  assign fall       = ~in_run & run_d;
  assign write_en   = (state == CAPTURE) & in_valid;
  assign last_write = write_en & (wr_ptr == {NB_ADDR{1'b1}});

  // Status word: state in the top two bits, full flag below, count in the LSBs.
  always_comb begin
    status                     = '0;
    status[NB_GPIOS-1 -: 2]    = state;
    status[NB_GPIOS-3]         = out_full;
    status[NB_ADDR:0]          = count;
  end

  // Capture FSM; a write that fills the RAM wins over a simultaneous fall of in_run.
  always_ff @(posedge clock or posedge in_reset) begin
    if (in_reset) begin
      state    <= IDLE;
      run_d    <= 1'b0;
      wr_ptr   <= '0;
      count    <= '0;
      out_full <= 1'b0;
    end else begin
      run_d <= in_run;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= CAPTURE;
            wr_ptr   <= '0;
            count    <= '0;
            out_full <= 1'b0;
          end
        end
        CAPTURE: begin
          if (write_en) begin
            wr_ptr <= wr_ptr + NB_ADDR'(1);
            count  <= count + (NB_ADDR+1)'(1);
          end
          if (last_write) begin
            state    <= DONE;
            out_full <= 1'b1;
          end else if (fall) begin
            state <= IDLE;
          end
        end
        DONE: begin
          if (fall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (write_en) mem[wr_ptr] <= in_data;
  end

  // Read stage 1: every source and its select are registered together (read-first RAM).
  always_ff @(posedge clock or posedge in_reset) begin
    if (in_reset) begin
      sel_q    <= '0;
      ram_q    <= '0;
      status_q <= '0;
      live_q   <= '0;
    end else begin
      sel_q    <= in_read_devices;
      ram_q    <= mem[in_read_addr];
      status_q <= status;
      live_q   <= in_data;
    end
  end

  // Source select for read stage 2.
  always_comb begin
    out_next = '0;
    case (sel_q)
      NB_LOG_READ_DEVICES'(0): out_next = ram_q;
      NB_LOG_READ_DEVICES'(1): out_next = status_q;
      NB_LOG_READ_DEVICES'(2): out_next = live_q;
      default:                 out_next = '0;
    endcase
  end

  // Read stage 2: registered output word.
  always_ff @(posedge clock or posedge in_reset) begin
    if (in_reset) begin
      out_log_capture_data <= '0;
    end else begin
      out_log_capture_data <= out_next;
    end
  end

endmodule

// File: tb/tb_log_capture.sv
// Randomized directed bench for log_capture, checked against a behavioural model
// (array RAM, sample counter, pipelined expected readout).
module tb_log_capture;

  logic        clock = 1'b0;
  logic        in_reset = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_run = 1'b0;
  logic [1:0]  in_read_devices = 2'd0;
  logic [9:0]  in_read_addr = 10'd0;
  logic [31:0] out_log_capture_data;
  logic        out_full;

  int checks = 0;
  int errors = 0;

  // model state
  int          m_state = 0;   // 0 idle, 1 capture, 2 done
  int          m_count = 0;
  int          m_ptr = 0;
  bit          m_full = 1'b0;
  bit          m_run_d = 1'b0;
  logic [31:0] m_mem [1024];
  bit          m_known [1024];
  logic [31:0] v1 = 32'd0, v2 = 32'd0;
  bit          v1_ok = 1'b1, v2_ok = 1'b1;

  log_capture dut (
    .clock                (clock),
    .in_reset             (in_reset),
    .in_data              (in_data),
    .in_valid             (in_valid),
    .in_run               (in_run),
    .in_read_devices      (in_read_devices),
    .in_read_addr         (in_read_addr),
    .out_log_capture_data (out_log_capture_data),
    .out_full             (out_full)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [1:0]  st;
    logic [10:0] cnt;
    st  = 2'(m_state);
    cnt = 11'(m_count);
    return {st, m_full, 18'd0, cnt};
  endfunction

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    logic [31:0] src;
    bit          src_ok;
    bit          rise, fall;
    int          nxt;
    @(posedge clock);
    src_ok = 1'b1;
    case (in_read_devices)
      2'd0: begin src = m_mem[in_read_addr]; src_ok = m_known[in_read_addr]; end
      2'd1: src = model_status();
      2'd2: src = in_data;
      default: src = 32'd0;
    endcase
    v2 = v1; v2_ok = v1_ok;
    v1 = src; v1_ok = src_ok;
    rise = in_run && !m_run_d;
    fall = !in_run && m_run_d;
    nxt  = m_state;
    if (m_state == 0 && rise) begin
      nxt = 1; m_ptr = 0; m_count = 0; m_full = 1'b0;
    end else if (m_state == 1) begin
      if (in_valid) begin
        m_mem[m_ptr] = in_data;
        m_known[m_ptr] = 1'b1;
        m_count++;
        m_ptr = (m_ptr + 1) % 1024;
      end
      if (m_count == 1024) begin
        nxt = 2; m_full = 1'b1;
      end else if (fall) begin
        nxt = 0;
      end
    end else if (m_state == 2 && fall) begin
      nxt = 0;
    end
    m_state = nxt;
    m_run_d = in_run;
    #1;
    check("full", {31'd0, out_full}, {31'd0, m_full});
    if (v2_ok) check("out", out_log_capture_data, v2);
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    in_run   = 1'b0;
    #1;
    m_state = 0; m_count = 0; m_ptr = 0; m_full = 1'b0; m_run_d = 1'b0;
    v1 = 32'd0; v2 = 32'd0; v1_ok = 1'b1; v2_ok = 1'b1;
    check("rst_full", {31'd0, out_full}, 32'd0);
    check("rst_out", out_log_capture_data, 32'd0);
    @(posedge clock);
    #1;
    in_reset = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [1:0] sel, input logic [9:0] addr,
                             input logic [31:0] exp);
    in_read_devices = sel;
    in_read_addr    = addr;
    tick();
    tick();
    check(tag, out_log_capture_data, exp);
  endtask

  initial begin
    logic [31:0] d_new;
    logic [31:0] keep99;
    logic [9:0]  a;
    for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;

    // Reset with in_run low; status reads as zero.
    @(posedge clock); #1;
    do_reset();
    read_expect("rst_status", 2'd1, 10'd0, 32'h0000_0000);

    // Full ramp capture with random reads in the background.
    in_run = 1'b1;
    tick();
    for (int i = 0; i < 1024; i++) begin
      in_data = 32'(i); in_valid = 1'b1;
      in_read_devices = 2'($urandom_range(0, 3));
      in_read_addr = 10'($urandom);
      tick();
      if (i == 1022) check("not_full_yet", {31'd0, out_full}, 32'd0);
    end
    check("full_after_1024", {31'd0, out_full}, 32'd1);
    in_valid = 1'b0;
    read_expect("done_status", 2'd1, 10'd0, 32'hA000_0400);
    read_expect("ram0", 2'd0, 10'd0, 32'd0);
    read_expect("ram511", 2'd0, 10'd511, 32'd511);
    read_expect("ram1023", 2'd0, 10'd1023, 32'd1023);

    // Re-arm, then a ramp with in_valid high every other cycle.
    in_run = 1'b0; tick();
    in_run = 1'b1; tick();
    for (int i = 0; i < 2048; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = in_valid ? 32'(i / 2) : $urandom;
      in_read_devices = 2'($urandom_range(0, 3));
      in_read_addr = 10'($urandom);
      tick();
    end
    in_valid = 1'b0;
    check("full_half_rate", {31'd0, out_full}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      a = 10'($urandom);
      read_expect("ram_half_rate", 2'd0, a, {22'd0, a});
    end

    // Abort after 100 samples, with a read-during-write at address 50.
    in_run = 1'b0; tick();
    in_run = 1'b1; tick();
    keep99 = 32'd0;
    for (int i = 0; i < 100; i++) begin
      d_new = $urandom;
      in_data = d_new; in_valid = 1'b1;
      if (i == 99) keep99 = d_new;
      if (i == 50) begin
        in_read_devices = 2'd0; in_read_addr = 10'd50;
        tick();
        in_valid = 1'b0;
        tick();
        check("rdw_old", out_log_capture_data, 32'd50);
        tick();
        check("rdw_new", out_log_capture_data, d_new);
      end else begin
        in_read_devices = 2'($urandom_range(0, 3));
        in_read_addr = 10'($urandom);
        tick();
      end
    end
    in_valid = 1'b0;
    in_run = 1'b0; tick();
    read_expect("abort_status", 2'd1, 10'd0, 32'h0000_0064);
    read_expect("abort_ram99", 2'd0, 10'd99, keep99);
    read_expect("abort_ram100", 2'd0, 10'd100, 32'd100);
    in_run = 1'b1; tick();
    read_expect("rearm_status", 2'd1, 10'd0, 32'h4000_0000);

    // Reset at sample 500 of a capture.
    for (int i = 0; i < 500; i++) begin
      in_data = $urandom; in_valid = 1'b1;
      in_read_devices = 2'($urandom_range(0, 3));
      in_read_addr = 10'($urandom);
      tick();
    end
    do_reset();
    read_expect("post_rst_status", 2'd1, 10'd0, 32'h0000_0000);

    // Live sample readout; in_valid toggles but nothing is written in IDLE.
    in_read_devices = 2'd2;
    for (int i = 0; i < 40; i++) begin
      in_data  = $urandom;
      in_valid = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    read_expect("idle_no_write", 2'd0, 10'd600, 32'd600);
    read_expect("sel3_zero", 2'd3, 10'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
